button_event_ctrl: RTL and testbench



---
 rtl/btn_pkg.sv | 12 +
 rtl/btn_filter.sv | 70 +++++++
 rtl/button_event_ctrl.sv | 119 +++++++++++
 tb/tb_button_event_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared event encodings for the push-button event controller.
package btn_pkg;

    typedef logic [1:0] ev_kind_t;

    localparam ev_kind_t EV_PRESS   = 2'd0;
    localparam ev_kind_t EV_RELEASE = 2'd1;
    localparam ev_kind_t EV_LONG    = 2'd2;

    localparam int NUM_SLOTS = 3;

endpackage

// File: rtl/btn_filter.sv
// One button: 2-FF synchroniser, tick-based stability filter and long-press timer.
// Raise outputs are combinational so the pending slot is set on the same edge that the level changes.
module btn_filter #(
    parameter int STABLE_TICKS = 16,
    parameter int LONG_TICKS   = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    logic [1:0]  sync_q;
    logic        level_q, level_d;
    logic [7:0]  stab_q, stab_d;
    logic [15:0] hold_q, hold_d;
    logic        s;

    assign s       = sync_q[1];
    assign level_o = level_q;

    always_comb begin
        level_d   = level_q;
        stab_d    = stab_q;
        hold_d    = hold_q;
        press_o   = 1'b0;
        release_o = 1'b0;
        long_o    = 1'b0;

        if (s == level_q) begin
            stab_d = '0;
        end else if (tick_i) begin
            if (stab_q == 8'(STABLE_TICKS - 1)) begin
                level_d   = ~level_q;
                stab_d    = '0;
                press_o   = ~level_q;
                release_o = level_q;
            end else begin
                stab_d = stab_q + 8'd1;
            end
        end

        // Saturating at LONG_TICKS makes the long event fire once per press.
        if (press_o || release_o) begin
            hold_d = '0;
        end else if (level_q && tick_i && (hold_q != 16'(LONG_TICKS))) begin
            hold_d = hold_q + 16'd1;
            long_o = (hold_q == 16'(LONG_TICKS - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            stab_q  <= '0;
            hold_q  <= '0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            level_q <= level_d;
            stab_q  <= stab_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: rtl/button_event_ctrl.sv
// N debounced buttons sharing one tick prescaler; press/release/long events are
// queued in per-button slots and served round-robin over one valid/ready port.
module button_event_ctrl
    import btn_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 16,
    parameter int LONG_TICKS   = 1000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_BTN-1:0]         btn_raw,
    output logic [N_BTN-1:0]         btn_level,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [$clog2(N_BTN)-1:0] ev_id,
    output ev_kind_t                 ev_kind,
    output logic                     ev_drop
);

    localparam int ID_W = $clog2(N_BTN);
    localparam int PW   = $clog2(TICK_DIV);

    logic [PW-1:0]                    presc_q;
    logic                             tick;
    logic [N_BTN-1:0][NUM_SLOTS-1:0] raise, pend_q, pend_d, clr;
    logic                             valid_q, valid_d, drop_q, drop_d;
    logic [ID_W-1:0]                  id_q, id_d, rr_q, rr_d, gnt_b;
    ev_kind_t                         kind_q, kind_d, gnt_kind;
    logic                             found, load;
    int                               gnt_idx, idx;

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    for (genvar g = 0; g < N_BTN; g++) begin : g_filt
        btn_filter #(
            .STABLE_TICKS (STABLE_TICKS),
            .LONG_TICKS   (LONG_TICKS)
        ) u_filt (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick_i    (tick),
            .raw_i     (btn_raw[g]),
            .level_o   (btn_level[g]),
            .press_o   (raise[g][EV_PRESS]),
            .release_o (raise[g][EV_RELEASE]),
            .long_o    (raise[g][EV_LONG])
        );
    end

    // Round-robin search from rr_q; within a button press beats long beats release.
    always_comb begin
        found    = 1'b0;
        gnt_idx  = 0;
        gnt_kind = EV_PRESS;
        idx      = 0;
        for (int k = 0; k < N_BTN; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N_BTN) idx = idx - N_BTN;
            if (!found && (pend_q[ID_W'(idx)] != '0)) begin
                found   = 1'b1;
                gnt_idx = idx;
                if (pend_q[ID_W'(idx)][EV_PRESS])     gnt_kind = EV_PRESS;
                else if (pend_q[ID_W'(idx)][EV_LONG]) gnt_kind = EV_LONG;
                else                                  gnt_kind = EV_RELEASE;
            end
        end
    end

    assign gnt_b = ID_W'(gnt_idx);
    assign load  = !valid_q || ev_ready;

    always_comb begin
        clr     = '0;
        valid_d = valid_q;
        id_d    = id_q;
        kind_d  = kind_q;
        rr_d    = rr_q;
        if (load) begin
            valid_d = found;
            if (found) begin
                clr[gnt_b][gnt_kind] = 1'b1;
                id_d   = gnt_b;
                kind_d = gnt_kind;
                rr_d   = (gnt_idx == N_BTN - 1) ? '0 : ID_W'(gnt_idx + 1);
            end
        end
        // A new raise wins over a same-cycle grant clear and is not a drop.
        pend_d = (pend_q & ~clr) | raise;
        drop_d = |(raise & pend_q & ~clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            pend_q  <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            kind_q  <= EV_PRESS;
            drop_q  <= 1'b0;
            rr_q    <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
            pend_q  <= pend_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            kind_q  <= kind_d;
            drop_q  <= drop_d;
            rr_q    <= rr_d;
        end
    end

    assign ev_valid = valid_q;
    assign ev_id    = id_q;
    assign ev_kind  = kind_q;
    assign ev_drop  = drop_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl with N_BTN=4, TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=10.
module tb_button_event_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic       ev_valid;
    logic       ev_ready;
    logic [1:0] ev_id;
    logic [1:0] ev_kind;
    logic       ev_drop;

    button_event_ctrl #(
        .N_BTN        (4),
        .TICK_DIV     (4),
        .STABLE_TICKS (3),
        .LONG_TICKS   (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_id     (ev_id),
        .ev_kind   (ev_kind),
        .ev_drop   (ev_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int kind;
        int cyc;
    } ev_t;

    ev_t evq[$];
    int  cyc = 0;
    int  n_vec = 0;
    int  n_err = 0;
    int  drops = 0;
    int  lvl1_cnt = 0;
    int  lvl0_rise = 0;
    bit  lvl0_prev = 1'b0;
    int  unstable = 0;
    bit  was_hold = 1'b0;
    int  h_id, h_kind;

    always @(posedge clk) cyc <= cyc + 1;

    // Transfers are sampled mid-cycle; they complete on the following rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ev_valid && ev_ready) evq.push_back('{int'(ev_id), int'(ev_kind), cyc});
            if (ev_drop) drops++;
            if (btn_level[1]) lvl1_cnt++;
            if (btn_level[0] && !lvl0_prev) lvl0_rise = cyc;
            lvl0_prev = btn_level[0];
            if (ev_valid && !ev_ready) begin
                if (was_hold && (int'(ev_id) != h_id || int'(ev_kind) != h_kind)) unstable++;
                was_hold = 1'b1;
                h_id     = int'(ev_id);
                h_kind   = int'(ev_kind);
            end else begin
                was_hold = 1'b0;
            end
        end else begin
            lvl0_prev = 1'b0;
            was_hold  = 1'b0;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input string tag, input int id, input int kind, output int c);
        ev_t e;
        if (evq.size() == 0) begin
            chk({tag, "_present"}, 0, 1);
            c = -100;
        end else begin
            e = evq.pop_front();
            chk({tag, "_id"}, e.id, id);
            chk({tag, "_kind"}, e.kind, kind);
            c = e.cyc;
        end
    endtask

    task automatic burst(input string tag, input int first, input int kind);
        int c, prev_c;
        prev_c = 0;
        for (int i = 0; i < 4; i++) begin
            expect_ev($sformatf("%s_%0d", tag, i), (first + i) % 4, kind, c);
            if (i > 0) chk($sformatf("%s_seq%0d", tag, i), c - prev_c, 1);
            prev_c = c;
        end
    endtask

    initial begin
        int c0, c, d, base;

        rst_n    = 1'b1;
        btn_raw  = 4'h0;
        ev_ready = 1'b0;
        #1 rst_n = 1'b0;
        step(3);
        chk("rst_level", int'(btn_level), 0);
        chk("rst_valid", int'(ev_valid), 0);
        chk("rst_id", int'(ev_id), 0);
        chk("rst_kind", int'(ev_kind), 0);
        chk("rst_drop", int'(ev_drop), 0);
        rst_n = 1'b1;
        step(2);

        // Clean press on button 0, then its release
        ev_ready = 1'b1;
        evq.delete();
        c0 = cyc;
        btn_raw[0] = 1'b1;
        step(40);
        chk("t1_level", int'(btn_level[0]), 1);
        d = lvl0_rise - c0;
        chk("t1_rise_window", (d >= 10 && d <= 18) ? 1 : 0, 1);
        chk("t1_count", evq.size(), 1);
        expect_ev("t1_press", 0, 0, c);
        chk("t1_latency", c - lvl0_rise, 1);
        btn_raw[0] = 1'b0;
        step(30);
        chk("t1_level_low", int'(btn_level[0]), 0);
        expect_ev("t1_rel", 0, 1, c);
        chk("t1_empty", evq.size(), 0);

        // Bounce on button 1 never qualifies
        base = lvl1_cnt;
        for (int i = 0; i < 10; i++) begin
            btn_raw[1] = ~btn_raw[1];
            step(6);
        end
        step(30);
        chk("t2_level_hi_cycles", lvl1_cnt - base, 0);
        chk("t2_no_events", evq.size(), 0);

        // Long press on button 2
        btn_raw[2] = 1'b1;
        step(80);
        btn_raw[2] = 1'b0;
        step(30);
        expect_ev("t3_press", 2, 0, c);
        expect_ev("t3_long", 2, 2, c);
        expect_ev("t3_rel", 2, 1, c);
        chk("t3_empty", evq.size(), 0);

        // Round robin: fresh reset so rr_ptr starts at 0
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        evq.delete();
        btn_raw = 4'hF;
        step(24);
        burst("t4_press_all", 0, 0);
        btn_raw = 4'h0;
        step(24);
        burst("t4_rel_all", 0, 1);
        btn_raw = 4'h2;
        step(24);
        btn_raw = 4'h0;
        step(24);
        expect_ev("t4_b1_press", 1, 0, c);
        expect_ev("t4_b1_rel", 1, 1, c);
        btn_raw = 4'hF;
        step(24);
        burst("t4_press_rot", 2, 0);
        btn_raw = 4'h0;
        step(24);
        burst("t4_rel_rot", 2, 1);
        chk("t4_empty", evq.size(), 0);

        // Backpressure: button 3 pressed/released twice with the port stalled
        ev_ready = 1'b0;
        base = drops;
        unstable = 0;
        btn_raw[3] = 1'b1;
        step(24);
        chk("t5_valid", int'(ev_valid), 1);
        chk("t5_id", int'(ev_id), 3);
        chk("t5_kind", int'(ev_kind), 0);
        btn_raw[3] = 1'b0;
        step(24);
        btn_raw[3] = 1'b1;
        step(24);
        btn_raw[3] = 1'b0;
        step(24);
        chk("t5_drops", drops - base, 1);
        chk("t5_hold_stable", unstable, 0);
        chk("t5_no_transfer", evq.size(), 0);
        ev_ready = 1'b1;
        step(10);
        expect_ev("t5_drain0", 3, 0, c);
        expect_ev("t5_drain1", 3, 0, c);
        expect_ev("t5_drain2", 3, 1, c);
        chk("t5_empty", evq.size(), 0);
        chk("t5_idle", int'(ev_valid), 0);

        // Reset while button 0 is held and a long event is pending behind a stalled port
        ev_ready = 1'b0;
        btn_raw[0] = 1'b1;
        step(70);
        chk("t6_pre_level", int'(btn_level[0]), 1);
        chk("t6_pre_valid", int'(ev_valid), 1);
        rst_n = 1'b0;
        btn_raw = 4'h0;
        @(negedge clk);
        chk("t6_rst_level", int'(btn_level), 0);
        chk("t6_rst_valid", int'(ev_valid), 0);
        chk("t6_rst_id", int'(ev_id), 0);
        chk("t6_rst_kind", int'(ev_kind), 0);
        chk("t6_rst_drop", int'(ev_drop), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ev_ready = 1'b1;
        step(30);
        chk("t6_no_stale", evq.size(), 0);
        chk("t6_valid_after", int'(ev_valid), 0);
        chk("t6_level_after", int'(btn_level), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
